// File: rtl/seg7_pkg.sv
// Shared seven-segment encoding and decoder helper, used by both the driver and the receive-side decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } seg7_dec_t;

  // A-G active-high; anything that is neither a digit nor all-off is flagged as an error.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t d;
    d.digit = DIGIT_NONE;
    d.blank = 1'b0;
    d.err   = 1'b0;
    case (seg)
      SEG_0:     d.digit = 4'd0;
      SEG_1:     d.digit = 4'd1;
      SEG_2:     d.digit = 4'd2;
      SEG_3:     d.digit = 4'd3;
      SEG_4:     d.digit = 4'd4;
      SEG_5:     d.digit = 4'd5;
      SEG_6:     d.digit = 4'd6;
      SEG_7:     d.digit = 4'd7;
      SEG_8:     d.digit = 4'd8;
      SEG_9:     d.digit = 4'd9;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.err   = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder_stability_filter.sv
// Synchronises the raw segment lines and strobes once when a pattern has held for STABLE_CYCLES clocks.
module seg7_stability_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] seg_i,
  output logic [7:0] pattern_o,
  output logic       settle_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(STABLE_CYCLES - 1);

  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    s;

  assign s = SEG_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Counter saturates so a long-held pattern never re-triggers the strobe.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      cand_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign settle_o  = (s == cand_q) && (cnt_q == CNT_SETTLE);
  assign pattern_o = cand_q;

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Decodes settled seven-segment patterns back to BCD and hands them out over valid/ready.
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 64,
  parameter bit CHANGE_ONLY    = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_dp,
  output logic       out_blank,
  output logic       out_err,
  output logic       overrun
);

  logic [7:0] pattern;
  logic       settle;
  seg7_dec_t  dec;

  out_state_e state_q;
  logic [7:0] last_q;
  logic       lastValid_q;
  logic [3:0] digit_q;
  logic       dp_q, blank_q, err_q, overrun_q;

  logic sameAsLast, wantEmit, canLoad, emit, drop;

  seg7_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_filter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .seg_i    (seg_in),
    .pattern_o(pattern),
    .settle_o (settle)
  );

  assign dec = seg7_decode(pattern[7:1]);

  // A held output may be replaced only in the cycle the consumer takes it.
  always_comb begin
    sameAsLast = lastValid_q && (pattern == last_q);
    wantEmit   = settle && !(CHANGE_ONLY && sameAsLast);
    canLoad    = (state_q == EMPTY) || out_ready;
    emit       = wantEmit && canLoad;
    drop       = wantEmit && !canLoad;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= EMPTY;
      last_q      <= 8'h00;
      lastValid_q <= 1'b0;
      digit_q     <= DIGIT_NONE;
      dp_q        <= 1'b0;
      blank_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= drop;
      if (emit) begin
        state_q     <= FULL;
        last_q      <= pattern;
        lastValid_q <= 1'b1;
        digit_q     <= dec.digit;
        dp_q        <= pattern[0];
        blank_q     <= dec.blank;
        err_q       <= dec.err;
      end else if ((state_q == FULL) && out_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_digit = digit_q;
  assign out_dp    = dp_q;
  assign out_blank = blank_q;
  assign out_err   = err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Receive-side counterpart of the seven-segment digit driver: samples 8 segment lines {A,B,C,D,E,F,G,DP}, waits for a settled pattern, and decodes it back to a BCD digit.
- Rejects crossfade/PWM dither between two patterns by requiring the pattern to hold for STABLE_CYCLES consecutive clocks.
- Delivers decoded digits over a valid/ready interface to loopback self-test logic or a display-capture monitor.

Parameters:
- STABLE_CYCLES, 64, consecutive identical synced samples required before a pattern counts as settled; must be ≥2 and larger than the longest dither run of the source.
- CHANGE_ONLY, 1, 1 = emit only when the settled pattern differs from the last emitted one; 0 = emit on every settle event.
- SEG_ACTIVE_LOW, 0, 1 = invert segment inputs after synchronisation (common-anode wiring).

Ports:
- CLK  input  1  system clock (16 MHz)
- RST_N  input  1  asynchronous active-low reset
- seg_in  input  8  {A,B,C,D,E,F,G,DP}, MSB = A; asynchronous to CLK
- out_valid  output  1  decoded digit available
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_digit  output  4  BCD 0–9; 4'hF for blank or illegal pattern
- out_dp  output  1  decimal point of the emitted pattern
- out_blank  output  1  emitted pattern had all of A–G off
- out_err  output  1  emitted pattern was not a legal digit and not blank
- overrun  output  1  one-cycle pulse: settle event dropped because the output was still held

Behaviour:
- Reset (RST_N low, async): sync regs, cand, last emitted pattern = 8'h00; cnt = 0; out_valid = 0; out_digit = 4'hF; out_dp/out_blank/out_err/overrun = 0; last-emitted marked invalid, so the first settle always emits.
- Input path: 2-FF synchroniser on all 8 bits, then optional inversion → s[7:0].
- Stability tracker:
  - If s != cand: cand <= s, cnt <= 0.
  - Else: cnt increments, saturating at STABLE_CYCLES. cnt width = clog2(STABLE_CYCLES+1).
  - Settle event = single-cycle strobe when s == cand and cnt == STABLE_CYCLES-1. It fires once per settled run and does not re-fire while saturated.
- Decode of A–G, active-high, pure function:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - 0000000 → blank (digit F, blank = 1)
  - Any other pattern → err = 1, digit F.
  - DP passes through.
- Emit decision on a settle event:
  - Skip if CHANGE_ONLY = 1 and the pattern equals the last emitted pattern (all 8 bits).
  - Else, if out_valid = 0 or (out_valid && out_ready) this cycle: register the decode, set out_valid = 1, update last emitted.
  - Else: drop the event, pulse overrun, leave last emitted unchanged.
- Output handshake FSM with states EMPTY and FULL:
  - EMPTY → FULL on an accepted emit.
  - FULL → EMPTY on out_ready with no simultaneous emit.
  - FULL stays FULL on simultaneous accept and emit; the new data replaces the old in the same cycle.
  - Output data is stable while out_valid && !out_ready.
- Latency: a constant seg_in applied before clock edge k (previous settled pattern different) gives out_valid high after edge k + STABLE_CYCLES + 2, i.e. STABLE_CYCLES+3 clocks.
- Dither: any alternation with run length < STABLE_CYCLES produces no settle event. Once the dither stops, the final pattern emits with the normal latency.
- Reset mid-operation: the pending output is discarded; no spurious out_valid after release.
- Illegal patterns are emitted (err = 1), never silently dropped.

Decomposition:
- Package seg7_pkg holds:
  - the 7-bit segment constants SEG_0…SEG_9 and SEG_BLANK;
  - DIGIT_NONE = 4'hF;
  - the output FSM state typedef (EMPTY, FULL).
  The driver side shares the same encoding constants.
- One sub-module, seg7_stability_filter: synchroniser, optional inversion, cand/cnt tracker, settle strobe. The decoder and handshake stay in the top module.

Test Plan:
- STABLE_CYCLES = 4. Reset, then hold seg_in = 8'b1101101_0 → out_valid rises exactly 7 clocks after the first sampled edge; out_digit = 2, dp = 0, blank = 0, err = 0; held with out_ready = 0.
- Alternate 3→4 patterns in runs of 1–3 cycles for 50 cycles, then hold 4 → no emit during the dither; exactly one emit of digit 4 after the hold.
- CHANGE_ONLY = 1: hold 7, break with a 2-cycle glitch, return to 7 → one emit only. With CHANGE_ONLY = 0 → two emits of 7.
- out_ready = 0 while 1 then 5 settle → the second settle pulses overrun once; out_digit stays 1. Raise ready → 1 accepted, out_valid drops.
- Apply 0000000_1 → digit F, blank = 1, dp = 1. Apply 1000001_0 → digit F, err = 1.
- Assert RST_N low while out_valid = 1 → all outputs return to reset values in the same cycle (async). After release, the same pattern re-emits once, STABLE_CYCLES+3 clocks later.
